// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - I2C master byte engine: optional START, one byte write/read with ACK, optional STOP
// Define I2C_CLK_STRETCH_EN to freeze the phase counter while a slave holds SCL low in P1.
module i2c_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_write,
  input  logic       cmd_read,
  input  logic       cmd_stop,
  input  logic       cmd_ack,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       rx_ack,
  output logic       done,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    dout_q, dout_d;
  logic          rx_ack_q, rx_ack_d;
  logic          hold_q, hold_d;
  logic          write_q, write_d;
  logic          read_q, read_d;
  logic          stop_q, stop_d;
  logic          ack_q, ack_d;

  logic busy, tick, last, sample, stall;

  assign busy   = (state_q == S_START) || (state_q == S_BIT) ||
                  (state_q == S_ACK) || (state_q == S_STOP);
  assign tick   = (cnt_q == CNT_LAST);
  assign last   = tick && (phase_q == 2'd3);
  assign sample = tick && (phase_q == 2'd2);

`ifdef I2C_CLK_STRETCH_EN
  assign stall = busy && (phase_q == 2'd1) && !scl_oe && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stall = 1'b0;
`endif

  // Bus drive is decoded from state/phase; hold_q keeps SCL low between chained commands.
  always_comb begin
    scl_oe = hold_q;
    sda_oe = 1'b0;
    case (state_q)
      S_START: begin
        scl_oe = (phase_q == 2'd3);
        sda_oe = (phase_q >= 2'd2);
      end
      S_BIT: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = write_q && !shreg_q[7];
      end
      S_ACK: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = read_q && !ack_q;
      end
      S_STOP: begin
        scl_oe = (phase_q == 2'd0);
        sda_oe = (phase_q <= 2'd1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    rx_ack_d = rx_ack_q;
    hold_d   = hold_q;
    write_d  = write_q;
    read_d   = read_q;
    stop_d   = stop_q;
    ack_d    = ack_q;

    if (busy && !stall) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          read_d  = cmd_read && !cmd_write;
          stop_d  = cmd_stop;
          ack_d   = cmd_ack;
          shreg_d = din;
          bit_d   = 3'd0;
          if (cmd_start)                  state_d = S_START;
          else if (cmd_write || cmd_read) state_d = S_BIT;
          else if (cmd_stop)              state_d = S_STOP;
          else                            state_d = S_DONE;
        end
      end
      S_START: begin
        if (last) begin
          hold_d = 1'b1;
          if (write_q || read_q) state_d = S_BIT;
          else if (stop_q)       state_d = S_STOP;
          else                   state_d = S_DONE;
        end
      end
      S_BIT: begin
        if (sample && read_q) shreg_d = {shreg_q[6:0], sda_i};
        if (last) begin
          bit_d = bit_q + 3'd1;
          if (write_q) shreg_d = {shreg_q[6:0], 1'b0};
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (sample && write_q) rx_ack_d = sda_i;
        if (last) begin
          hold_d = 1'b1;
          if (read_q) dout_d = shreg_q;
          state_d = stop_q ? S_STOP : S_DONE;
        end
      end
      S_STOP: begin
        if (last) begin
          hold_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      bit_q    <= 3'd0;
      shreg_q  <= 8'h00;
      dout_q   <= 8'h00;
      rx_ack_q <= 1'b0;
      hold_q   <= 1'b0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      stop_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      rx_ack_q <= rx_ack_d;
      hold_q   <= hold_d;
      write_q  <= write_d;
      read_q   <= read_d;
      stop_q   <= stop_d;
      ack_q    <= ack_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dout      = dout_q;
  assign rx_ack    = rx_ack_q;

endmodule
